ahb3lite_plic_stim_master: RTL

Synthesizable AHB3-Lite master that turns a queued stream of register commands into pipelined single transfers on the PLIC slave port and returns read data, error and compare status per command. It replaces hand-driven bus tasks in the next-generation PLIC bench: the bench top instantiates it between the test sequencer and `ahb3lite_plic_top`. It is parametrised in address/data width and queue depth, and adds wait-state, error-response and read-compare handling.

---
 rtl/ahb3lite_pkg.sv | 26 ++
 rtl/ahb3lite_plic_stim_fifo.sv | 33 +++
 rtl/ahb3lite_plic_stim_master.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: AHB3-Lite encodings and the stimulus command record.
// Command fields are sized for the widest supported bus; users slice them down.
package ahb3lite_pkg;
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;
   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;
   localparam int STIM_AW = 32;
   localparam int STIM_DW = 64;
   typedef struct packed {
      logic               write;
      logic [2:0]         size;
      logic [STIM_AW-1:0] addr;
      logic [STIM_DW-1:0] data;
      logic [STIM_DW-1:0] mask;
   } stim_cmd_t;
   localparam stim_cmd_t STIM_CMD_NONE = '0;
endpackage

// File: rtl/ahb3lite_plic_stim_fifo.sv
// ahb3lite_plic_stim_fifo: synchronous command FIFO; pointers carry an extra
// wrap bit so full and empty are told apart without a counter.
module ahb3lite_plic_stim_fifo
   import ahb3lite_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic      HCLK,
   input  logic      HRESETn,
   input  logic      push,
   input  stim_cmd_t din,
   input  logic      pop,
   output stim_cmd_t dout,
   output logic      empty,
   output logic      full
);
   localparam int AW = $clog2(DEPTH);
   stim_cmd_t mem [DEPTH];
   logic [AW:0] wp, rp;
   assign empty = wp == rp;
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign dout  = mem[rp[AW-1:0]];
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   always_ff @(posedge HCLK)
      if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ahb3lite_plic_stim_master.sv
// ahb3lite_plic_stim_master: queued register commands to pipelined AHB3-Lite single
// transfers with per-command response; PLIC_STIM_CMP_EN adds the read compare.
module ahb3lite_plic_stim_master
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE = 16,
   parameter int HDATA_SIZE = 32,
   parameter int CMD_DEPTH  = 4,
   parameter int CNT_SIZE   = 16
)(
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [2:0]            cmd_size,
   input  logic [HADDR_SIZE-1:0] cmd_addr,
   input  logic [HDATA_SIZE-1:0] cmd_data,
   input  logic [HDATA_SIZE-1:0] cmd_mask,
   output logic                  rsp_valid,
   output logic [HDATA_SIZE-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_mismatch,
   output logic [CNT_SIZE-1:0]   err_cnt,
   output logic [CNT_SIZE-1:0]   mis_cnt,
   output logic                  idle,
   output logic                  HSEL,
   output logic [HADDR_SIZE-1:0] HADDR,
   output logic [HDATA_SIZE-1:0] HWDATA,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [1:0]            HTRANS,
   output logic                  HMASTLOCK,
   input  logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);
   stim_cmd_t cmd_in, head, ap, dp;
   logic fifo_empty, fifo_full, accept, adv, push, pop, done;
   logic ap_valid, dp_valid, cancel, issue;
   logic unused;

   assign cmd_in = '{write: cmd_write, size: cmd_size, addr: STIM_AW'(cmd_addr),
                     data: STIM_DW'(cmd_data), mask: STIM_DW'(cmd_mask)};
   assign cmd_ready = !fifo_full;
   assign accept    = cmd_valid && cmd_ready;
   // a cancelled address phase keeps its command for reissue, so AP refills only when not held
   assign adv   = HREADY && !cancel;
   assign pop   = adv && !fifo_empty;
   assign push  = accept && !(adv && fifo_empty);
   assign done  = dp_valid && HREADY;
   assign issue = ap_valid && !cancel;
   assign idle  = fifo_empty && !ap_valid && !dp_valid;

   assign HSEL      = issue;
   assign HTRANS    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR     = ap.addr[HADDR_SIZE-1:0];
   assign HWRITE    = ap.write;
   assign HSIZE     = ap.size;
   assign HWDATA    = (dp_valid && dp.write) ? dp.data[HDATA_SIZE-1:0] : '0;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_DATA_PRIV;
   assign HMASTLOCK = 1'b0;
   assign unused    = ^dp;

   ahb3lite_plic_stim_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .push    (push),
      .din     (cmd_in),
      .pop     (pop),
      .dout    (head),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         ap_valid <= 1'b0;
         dp_valid <= 1'b0;
         cancel   <= 1'b0;
         ap       <= STIM_CMD_NONE;
         dp       <= STIM_CMD_NONE;
      end else if (HREADY) begin
         cancel   <= 1'b0;
         dp_valid <= issue;
         dp       <= ap;
         if (!cancel) begin
            ap_valid <= !fifo_empty || accept;
            ap       <= !fifo_empty ? head : accept ? cmd_in : STIM_CMD_NONE;
         end
      end else if (HRESP && issue)
         cancel <= 1'b1;

   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         err_cnt   <= '0;
      end else begin
         rsp_valid <= done;
         rsp_rdata <= (done && !dp.write) ? HRDATA : '0;
         rsp_err   <= done && HRESP;
         if (done && HRESP && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end

`ifdef PLIC_STIM_CMP_EN
   logic mis;
   assign mis = done && !dp.write && !HRESP &&
                |((HRDATA ^ dp.data[HDATA_SIZE-1:0]) & dp.mask[HDATA_SIZE-1:0]);
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         rsp_mismatch <= 1'b0;
         mis_cnt      <= '0;
      end else begin
         rsp_mismatch <= mis;
         if (mis && mis_cnt != '1) mis_cnt <= mis_cnt + 1'b1;
      end
`else
   assign rsp_mismatch = 1'b0;
   assign mis_cnt      = '0;
`endif
endmodule
